dmem_arbiter: RTL



---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_starve_cnt.sv | 35 +++
 rtl/dmem_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and width defaults for the data-memory arbiter and its helpers.
package dmem_arbiter_pkg;

   // Defaults mirror the core's memory index width and data word width.
   localparam int unsigned DEF_ADDR_W = 10;
   localparam int unsigned DEF_DATA_W = 64;

   typedef enum logic {
      ReqCore = 1'b0,
      ReqAux  = 1'b1
   } req_id_e;

   typedef enum logic {
      StCorePri  = 1'b0,
      StAuxForce = 1'b1
   } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and DataMem signals of the arbiter; slave is the arbiter view, master the
// view of the requesters plus memory.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = dmem_arbiter_pkg::DEF_ADDR_W,
   parameter int unsigned DATA_W = dmem_arbiter_pkg::DEF_DATA_W
) ();

   logic              core_req_i;
   logic              core_we_i;
   logic [ADDR_W-1:0] core_addr_i;
   logic [DATA_W-1:0] core_wdata_i;
   logic              core_gnt_o;
   logic              core_rvalid_o;
   logic [DATA_W-1:0] core_rdata_o;

   logic              aux_req_i;
   logic              aux_we_i;
   logic [ADDR_W-1:0] aux_addr_i;
   logic [DATA_W-1:0] aux_wdata_i;
   logic              aux_gnt_o;
   logic              aux_rvalid_o;
   logic [DATA_W-1:0] aux_rdata_o;

   logic              mem_we_o;
   logic              mem_re_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;

   modport slave (
      input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
      input  aux_req_i, aux_we_i, aux_addr_i, aux_wdata_i,
      input  mem_rdata_i,
      output core_gnt_o, core_rvalid_o, core_rdata_o,
      output aux_gnt_o, aux_rvalid_o, aux_rdata_o,
      output mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output core_req_i, core_we_i, core_addr_i, core_wdata_i,
      output aux_req_i, aux_we_i, aux_addr_i, aux_wdata_i,
      output mem_rdata_i,
      input  core_gnt_o, core_rvalid_o, core_rdata_o,
      input  aux_gnt_o, aux_rvalid_o, aux_rdata_o,
      input  mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o
   );

endinterface

// File: rtl/dmem_starve_cnt.sv
// Saturating count of consecutive aux denials; raises force_aux on the denial that
// brings the count to MAX_WAIT so the next cycle favours aux.
module dmem_starve_cnt #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic aux_req,
   input  logic aux_gnt,
   output logic force_aux
);

   localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d     = '0;
      force_aux = 1'b0;
      if (aux_req && !aux_gnt) begin
         cnt_d     = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
         force_aux = (cnt_d == CntMax);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port DataMem: core has priority, aux is
// force-granted after MAX_WAIT consecutive denials; read data returns one cycle after grant.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   dmem_arbiter_if.slave bus
);

   arb_state_e        state_q, state_d;
   logic              core_gnt, aux_gnt, force_aux;
   logic              mem_we, mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              resp_valid_q;
   req_id_e           resp_sel_q;
   logic [DATA_W-1:0] core_rdata_q, aux_rdata_q;

   dmem_starve_cnt #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .aux_req   (bus.aux_req_i),
      .aux_gnt   (aux_gnt),
      .force_aux (force_aux)
   );

   always_comb begin
      core_gnt = 1'b0;
      aux_gnt  = 1'b0;
      if (state_q == StAuxForce) begin
         if (bus.aux_req_i)       aux_gnt  = 1'b1;
         else if (bus.core_req_i) core_gnt = 1'b1;
      end else begin
         if (bus.core_req_i)      core_gnt = 1'b1;
         else if (bus.aux_req_i)  aux_gnt  = 1'b1;
      end
      // Forced aux turn lasts exactly one cycle.
      state_d = force_aux ? StAuxForce : StCorePri;
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (aux_gnt) begin
         mem_we    = bus.aux_we_i;
         mem_re    = ~bus.aux_we_i;
         mem_addr  = bus.aux_addr_i;
         mem_wdata = bus.aux_wdata_i;
      end else if (core_gnt) begin
         mem_we    = bus.core_we_i;
         mem_re    = ~bus.core_we_i;
         mem_addr  = bus.core_addr_i;
         mem_wdata = bus.core_wdata_i;
      end
   end

   // DataMem presents read data before the posedge ending the grant cycle.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= StCorePri;
         resp_valid_q <= 1'b0;
         resp_sel_q   <= ReqCore;
         core_rdata_q <= '0;
         aux_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= mem_re;
         if (mem_re) begin
            resp_sel_q <= aux_gnt ? ReqAux : ReqCore;
            if (aux_gnt) aux_rdata_q  <= bus.mem_rdata_i;
            else         core_rdata_q <= bus.mem_rdata_i;
         end
      end
   end

   assign bus.core_gnt_o    = core_gnt;
   assign bus.aux_gnt_o     = aux_gnt;
   assign bus.core_rvalid_o = resp_valid_q && (resp_sel_q == ReqCore);
   assign bus.aux_rvalid_o  = resp_valid_q && (resp_sel_q == ReqAux);
   assign bus.core_rdata_o  = core_rdata_q;
   assign bus.aux_rdata_o   = aux_rdata_q;
   assign bus.mem_we_o      = mem_we;
   assign bus.mem_re_o      = mem_re;
   assign bus.mem_addr_o    = mem_addr;
   assign bus.mem_wdata_o   = mem_wdata;

endmodule
